// File: rtl/xadac_obi_split.sv
// Vector-to-narrow OBI splitter: one wide request becomes MemW-wide beats,
// and the beat responses are gathered back into one tagged vector response.
module xadac_obi_split #(
    parameter int VecW  = 128,
    parameter int MemW  = 32,
    parameter int AddrW = 32,
    parameter int IdW   = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               vec_req_i,
    output logic               vec_gnt_o,
    input  logic [AddrW-1:0]   vec_addr_i,
    input  logic               vec_we_i,
    input  logic [VecW/8-1:0]  vec_be_i,
    input  logic [VecW-1:0]    vec_wdata_i,
    input  logic [IdW-1:0]     vec_aid_i,
    output logic               vec_rvalid_o,
    input  logic               vec_rready_i,
    output logic [VecW-1:0]    vec_rdata_o,
    output logic [IdW-1:0]     vec_rid_o,
    output logic               mem_req_o,
    input  logic               mem_gnt_i,
    output logic [AddrW-1:0]   mem_addr_o,
    output logic               mem_we_o,
    output logic [MemW/8-1:0]  mem_be_o,
    output logic [MemW-1:0]    mem_wdata_o,
    input  logic               mem_rvalid_i,
    input  logic [MemW-1:0]    mem_rdata_i
);

    localparam int NBeats = VecW / MemW;
    localparam int VB     = VecW / 8;
    localparam int MB     = MemW / 8;
    localparam int BW     = (NBeats > 1) ? $clog2(NBeats) : 1;
    localparam int CW     = $clog2(NBeats + 1);
    localparam int OW     = $clog2(MB);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        RESP
    } state_t;

    state_t              state_q;
    logic [AddrW-1:0]    base_q;
    logic                we_q;
    logic [VB-1:0]       be_q;
    logic [VecW-1:0]     wdata_q;
    logic [IdW-1:0]      aid_q;
    logic [NBeats-1:0]   ipend_q;
    logic [NBeats-1:0]   rpend_q;
    logic [VecW-1:0]     rbuf_q;
    logic [CW-1:0]       cnt_q;

    logic [NBeats-1:0]   req_mask;
    logic [BW-1:0]       issue_k;
    logic [BW-1:0]       rsp_k;
    logic [NBeats-1:0]   issue_bit;
    logic [NBeats-1:0]   rsp_bit;
    logic [NBeats-1:0]   ipend_nxt;
    logic [NBeats-1:0]   rpend_nxt;
    logic [CW-1:0]       cnt_nxt;
    logic [AddrW-1:0]    beat_off;
    logic                grant;
    logic                rsp_hit;

    function automatic logic [BW-1:0] lowest(input logic [NBeats-1:0] m);
        logic [BW-1:0] idx;
        idx = '0;
        for (int k = NBeats - 1; k >= 0; k--) begin
            if (m[k]) idx = BW'(k);
        end
        return idx;
    endfunction

    // A beat takes part only if at least one of its bytes is enabled
    always_comb begin
        req_mask = '0;
        for (int k = 0; k < NBeats; k++) begin
            req_mask[k] = |vec_be_i[k*MB +: MB];
        end
    end

    assign issue_k   = lowest(ipend_q);
    assign rsp_k     = lowest(rpend_q);
    assign issue_bit = NBeats'(1) << issue_k;
    assign rsp_bit   = NBeats'(1) << rsp_k;

    assign grant   = (state_q == ISSUE) && mem_gnt_i;
    assign rsp_hit = mem_rvalid_i && (cnt_q != '0) &&
                     ((state_q == ISSUE) || (state_q == DRAIN));

    assign ipend_nxt = grant ? (ipend_q & ~issue_bit) : ipend_q;
    assign rpend_nxt = rsp_hit ? (rpend_q & ~rsp_bit) : rpend_q;

    // Outstanding beats: grants add one, responses retire one
    always_comb begin
        cnt_nxt = cnt_q;
        if (grant && !rsp_hit) cnt_nxt = cnt_q + CW'(1);
        else if (!grant && rsp_hit) cnt_nxt = cnt_q - CW'(1);
    end

    assign vec_gnt_o = (state_q == IDLE) && vec_req_i && !rst_i;

    assign beat_off    = AddrW'(issue_k) << OW;
    assign mem_req_o   = (state_q == ISSUE);
    assign mem_addr_o  = mem_req_o ? (base_q + beat_off) : '0;
    assign mem_we_o    = mem_req_o && we_q;
    assign mem_be_o    = mem_req_o ? be_q[int'(issue_k)*MB +: MB] : '0;
    assign mem_wdata_o = mem_req_o ? wdata_q[int'(issue_k)*MemW +: MemW] : '0;

    assign vec_rvalid_o = (state_q == RESP);
    assign vec_rdata_o  = vec_rvalid_o ? rbuf_q : '0;
    assign vec_rid_o    = vec_rvalid_o ? aid_q : '0;

    // Transaction FSM: capture, issue beats, collect responses, respond
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            base_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            aid_q   <= '0;
            ipend_q <= '0;
            rpend_q <= '0;
            rbuf_q  <= '0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (vec_req_i) begin
                        base_q  <= vec_addr_i & ~AddrW'(VB - 1);
                        we_q    <= vec_we_i;
                        be_q    <= vec_be_i;
                        wdata_q <= vec_wdata_i;
                        aid_q   <= vec_aid_i;
                        ipend_q <= req_mask;
                        rpend_q <= req_mask;
                        rbuf_q  <= '0;
                        cnt_q   <= '0;
                        state_q <= (req_mask != '0) ? ISSUE : RESP;
                    end
                end
                ISSUE, DRAIN: begin
                    ipend_q <= ipend_nxt;
                    rpend_q <= rpend_nxt;
                    cnt_q   <= cnt_nxt;
                    if (rsp_hit && !we_q) begin
                        rbuf_q[int'(rsp_k)*MemW +: MemW] <= mem_rdata_i;
                    end
                    if (state_q == ISSUE) begin
                        if (grant && (ipend_nxt == '0)) begin
                            state_q <= (rpend_nxt == '0) ? RESP : DRAIN;
                        end
                    end else if (rpend_nxt == '0) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (vec_rready_i) state_q <= IDLE;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    // More beats in flight than a vector holds means the counter is broken
    always @(posedge clk_i) begin
        if (!rst_i) assert (cnt_q <= CW'(NBeats));
    end
`endif

endmodule

// File: tb/tb_xadac_obi_split.sv
// Bench for xadac_obi_split: scoreboard of expected beats and vector
// responses, with a one-cycle-latency narrow memory model.
module tb_xadac_obi_split;

    localparam int VecW  = 128;
    localparam int MemW  = 32;
    localparam int AddrW = 32;
    localparam int IdW   = 4;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        logic [127:0] rdata;
        logic [3:0]   rid;
        int           lat;
    } rsp_t;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         vec_req_i = 1'b0;
    logic         vec_gnt_o;
    logic [31:0]  vec_addr_i = '0;
    logic         vec_we_i = 1'b0;
    logic [15:0]  vec_be_i = '0;
    logic [127:0] vec_wdata_i = '0;
    logic [3:0]   vec_aid_i = '0;
    logic         vec_rvalid_o;
    logic         vec_rready_i = 1'b1;
    logic [127:0] vec_rdata_o;
    logic [3:0]   vec_rid_o;
    logic         mem_req_o;
    logic         mem_gnt_i = 1'b0;
    logic [31:0]  mem_addr_o;
    logic         mem_we_o;
    logic [3:0]   mem_be_o;
    logic [31:0]  mem_wdata_o;
    logic         mem_rvalid_i = 1'b0;
    logic [31:0]  mem_rdata_i = '0;

    beat_t        beat_q[$];
    rsp_t         rsp_q[$];
    logic [31:0]  mem_q[$];

    int           nchk = 0;
    int           nerr = 0;
    int           cyc = 0;
    int           acc_cyc = 0;
    int           gcnt = 0;
    int           stall_at = -1;
    int           stall_left = 0;
    bit           first_seen = 0;
    bit           hold_v = 0;
    bit           pend_v = 0;
    logic [31:0]  pend_d = '0;
    beat_t        hold;
    beat_t        mcur;
    beat_t        mexp;
    rsp_t         rexp;

    xadac_obi_split #(
        .VecW (VecW),
        .MemW (MemW),
        .AddrW(AddrW),
        .IdW  (IdW)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .vec_req_i   (vec_req_i),
        .vec_gnt_o   (vec_gnt_o),
        .vec_addr_i  (vec_addr_i),
        .vec_we_i    (vec_we_i),
        .vec_be_i    (vec_be_i),
        .vec_wdata_i (vec_wdata_i),
        .vec_aid_i   (vec_aid_i),
        .vec_rvalid_o(vec_rvalid_o),
        .vec_rready_i(vec_rready_i),
        .vec_rdata_o (vec_rdata_o),
        .vec_rid_o   (vec_rid_o),
        .mem_req_o   (mem_req_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_addr_o  (mem_addr_o),
        .mem_we_o    (mem_we_o),
        .mem_be_o    (mem_be_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Narrow memory: grants unless stalled, answers one cycle after grant
    always @(negedge clk_i) begin
        if (rst_i) begin
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = '0;
            pend_v       = 0;
            hold_v       = 0;
        end else begin
            mem_rvalid_i = pend_v;
            mem_rdata_i  = pend_d;
            pend_v       = 0;
            mem_gnt_i    = 1'b0;
            if (mem_req_o) begin
                mcur.addr  = mem_addr_o;
                mcur.we    = mem_we_o;
                mcur.be    = mem_be_o;
                mcur.wdata = mem_wdata_o;
                if (stall_left > 0 && gcnt == stall_at) begin
                    if (hold_v)
                        check("stall_hold",
                              128'({mcur.addr, mcur.we, mcur.be, mcur.wdata}),
                              128'({hold.addr, hold.we, hold.be, hold.wdata}));
                    else begin
                        hold   = mcur;
                        hold_v = 1;
                    end
                    stall_left--;
                end else begin
                    mem_gnt_i = 1'b1;
                    gcnt++;
                    hold_v = 0;
                    if (beat_q.size() == 0) begin
                        check("beat_extra", 128'(1), 128'(0));
                    end else begin
                        mexp = beat_q.pop_front();
                        check("beat_addr", 128'(mcur.addr), 128'(mexp.addr));
                        check("beat_ctl", 128'({mcur.we, mcur.be}),
                              128'({mexp.we, mexp.be}));
                        check("beat_wdata", 128'(mcur.wdata), 128'(mexp.wdata));
                    end
                    pend_v = 1;
                    if (mem_we_o) begin
                        pend_d = 32'hBAD0_BAD0;
                    end else if (mem_q.size() == 0) begin
                        pend_d = '0;
                        check("mem_data_missing", 128'(1), 128'(0));
                    end else begin
                        pend_d = mem_q.pop_front();
                    end
                end
            end
        end
    end

    // Response side: every valid cycle must show the scoreboard head
    always begin
        @(negedge clk_i);
        #2;
        if (!rst_i && vec_rvalid_o) begin
            if (rsp_q.size() == 0) begin
                check("rsp_extra", 128'(1), 128'(0));
            end else begin
                rexp = rsp_q[0];
                if (!first_seen) begin
                    first_seen = 1;
                    if (rexp.lat >= 0)
                        check("rsp_lat", 128'(cyc - acc_cyc), 128'(rexp.lat));
                end
                check("rsp_data", vec_rdata_o, rexp.rdata);
                check("rsp_id", 128'(vec_rid_o), 128'(rexp.rid));
                if (vec_rready_i) begin
                    void'(rsp_q.pop_front());
                    first_seen = 0;
                end
            end
        end
    end

    task automatic model_push(input logic [31:0] addr, input logic we,
                              input logic [15:0] be, input logic [127:0] wdata,
                              input logic [3:0] aid, input logic [127:0] mdata,
                              input int lat);
        beat_t       b;
        rsp_t        r;
        logic [31:0] base;
        base    = {addr[31:4], 4'h0};
        r.rdata = '0;
        r.rid   = aid;
        r.lat   = lat;
        for (int k = 0; k < 4; k++) begin
            if (be[k*4 +: 4] != 4'h0) begin
                b.addr  = base + 32'(k * 4);
                b.we    = we;
                b.be    = be[k*4 +: 4];
                b.wdata = wdata[k*32 +: 32];
                beat_q.push_back(b);
                if (!we) begin
                    mem_q.push_back(mdata[k*32 +: 32]);
                    r.rdata[k*32 +: 32] = mdata[k*32 +: 32];
                end
            end
        end
        rsp_q.push_back(r);
    endtask

    task automatic drive_req(input logic [31:0] addr, input logic we,
                             input logic [15:0] be, input logic [127:0] wdata,
                             input logic [3:0] aid);
        bit ok;
        ok = 0;
        @(negedge clk_i);
        vec_req_i   = 1'b1;
        vec_addr_i  = addr;
        vec_we_i    = we;
        vec_be_i    = be;
        vec_wdata_i = wdata;
        vec_aid_i   = aid;
        for (int i = 0; i < 50 && !ok; i++) begin
            #1;
            if (vec_gnt_o) begin
                ok      = 1;
                acc_cyc = cyc;
            end
            @(negedge clk_i);
        end
        vec_req_i = 1'b0;
        if (!ok) check("gnt_timeout", 128'(0), 128'(1));
    endtask

    task automatic issue(input logic [31:0] addr, input logic we,
                         input logic [15:0] be, input logic [127:0] wdata,
                         input logic [3:0] aid, input logic [127:0] mdata,
                         input int lat);
        model_push(addr, we, be, wdata, aid, mdata, lat);
        drive_req(addr, we, be, wdata, aid);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (rsp_q.size() != 0 && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        #3;
        check("done_timeout", 128'(rsp_q.size()), 128'(0));
        check("beats_left", 128'(beat_q.size()), 128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] wd;
        int           g0;
        int           n;

        repeat (3) @(negedge clk_i);
        #1;
        check("rst_vec", 128'({vec_gnt_o, vec_rvalid_o, vec_rid_o}), 128'(0));
        check("rst_vrdata", vec_rdata_o, 128'(0));
        check("rst_mem", 128'({mem_req_o, mem_addr_o, mem_we_o, mem_be_o,
                               mem_wdata_o}), 128'(0));
        @(negedge clk_i);
        rst_i = 1'b0;

        // full read, zero-wait memory
        issue(32'h1000, 1'b0, 16'hFFFF, '0, 4'd5,
              128'h44444444_33333333_22222222_11111111, 6);
        wait_done();

        // sparse write, unaligned address
        wd = 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001;
        issue(32'h2004, 1'b1, 16'h0F0F, wd, 4'd7, '0, 4);
        wait_done();

        // zero byte enables: no memory traffic
        issue(32'h2500, 1'b0, 16'h0000, '0, 4'd3, rnd128(), 1);
        wait_done();

        // beat 1 stalled three cycles
        stall_at   = gcnt + 1;
        stall_left = 3;
        issue(32'h1800, 1'b0, 16'hFFFF, '0, 4'd2, rnd128(), 9);
        wait_done();
        check("stall_used", 128'(stall_left), 128'(0));

        // response backpressure with a queued request
        vec_rready_i = 1'b0;
        issue(32'h3000, 1'b0, 16'h000F, '0, 4'd9, rnd128(), 3);
        n = 0;
        while (!vec_rvalid_o && n < 50) begin
            @(negedge clk_i);
            #2;
            n++;
        end
        check("bp_rvalid", 128'(vec_rvalid_o), 128'(1));
        wd = rnd128();
        model_push(32'h3100, 1'b1, 16'hFFFF, wd, 4'd6, '0, -1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            vec_req_i   = 1'b1;
            vec_addr_i  = 32'h3100;
            vec_we_i    = 1'b1;
            vec_be_i    = 16'hFFFF;
            vec_wdata_i = wd;
            vec_aid_i   = 4'd6;
            #1;
            check("bp_gnt_hold", 128'(vec_gnt_o), 128'(0));
        end
        @(negedge clk_i);
        vec_rready_i = 1'b1;
        #1;
        check("bp_gnt_hs", 128'(vec_gnt_o), 128'(0));
        @(negedge clk_i);
        #1;
        check("bp_gnt_next", 128'(vec_gnt_o), 128'(1));
        acc_cyc = cyc;
        @(negedge clk_i);
        vec_req_i = 1'b0;
        wait_done();

        // reset in the middle of a transaction
        g0 = gcnt;
        issue(32'h4000, 1'b0, 16'hFFFF, '0, 4'hA, rnd128(), -1);
        n = 0;
        while (gcnt < g0 + 2 && n < 50) begin
            @(negedge clk_i);
            #2;
            n++;
        end
        check("rst_wait", 128'(gcnt >= g0 + 2), 128'(1));
        @(negedge clk_i);
        #3;
        rst_i = 1'b1;
        #1;
        check("mid_rst_vec", 128'({vec_gnt_o, vec_rvalid_o, vec_rid_o}),
              128'(0));
        check("mid_rst_vrdata", vec_rdata_o, 128'(0));
        check("mid_rst_mem", 128'({mem_req_o, mem_addr_o, mem_we_o, mem_be_o,
                                   mem_wdata_o}), 128'(0));
        @(negedge clk_i);
        #3;
        beat_q.delete();
        mem_q.delete();
        rsp_q.delete();
        first_seen = 0;
        stall_left = 0;
        rst_i = 1'b0;

        issue(32'h5008, 1'b0, 16'hF0F0, '0, 4'hC, rnd128(), 4);
        wait_done();

        // a few random transactions
        for (int i = 0; i < 4; i++) begin
            issue($urandom, 1'($urandom), 16'($urandom), rnd128(), 4'(i),
                  rnd128(), -1);
            wait_done();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
